// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID-stage stall/flush/freeze controller with memory-wait watchdog and saturating counters
module hazard_stall_unit #(
  parameter int CNT_W = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic             IFID_Branch,
  input  logic             BranchTaken,
  input  logic [4:0]       IDEX_RegDest,
  input  logic [1:0]       IDEX_RegWrite,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       EXMEM_RegDest,
  input  logic             EXMEM_MemRead,
  input  logic             EXMEM_MemAccess,
  input  logic             DMem_Ready,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic             Freeze,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FreezeCount
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  typedef enum logic {RUN, LD_BR} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d, frzc_q, frzc_d;
  logic timeout_q, timeout_d;
  logic frz, ex_wr, m_ex, m_mem, lu, br_alu, br_ldex, br_ldmem, stall;
  assign frz = EXMEM_MemAccess && !DMem_Ready;
  assign ex_wr = |IDEX_RegWrite;
  assign m_ex = IDEX_RegDest != 5'd0 &&
                (IDEX_RegDest == IFID_Rs || (IFID_UsesRt && IDEX_RegDest == IFID_Rt));
  assign m_mem = EXMEM_RegDest != 5'd0 &&
                 (EXMEM_RegDest == IFID_Rs || (IFID_UsesRt && EXMEM_RegDest == IFID_Rt));
  assign lu = IDEX_MemRead && ex_wr && m_ex;
  assign br_alu = IFID_Branch && ex_wr && !IDEX_MemRead && m_ex;
  assign br_ldex = IFID_Branch && lu;
  assign br_ldmem = IFID_Branch && EXMEM_MemRead && m_mem;
  // LD_BR issues its pending stall without looking at the current hazard inputs
  assign stall = !frz && (state_q == LD_BR || lu || br_alu || br_ldmem);
  always_comb begin
    state_d = frz ? state_q : (state_q == RUN && br_ldex) ? LD_BR : RUN;
    PCWrite = !rst && !frz && !stall;
    IFID_Write = !rst && !frz && !stall;
    IDEX_Bubble = rst || stall;
    IFID_Flush = rst || (!frz && !stall && BranchTaken);
    Freeze = !rst && frz;
    wait_d = !frz ? '0 : (wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + WW'(1);
    timeout_d = timeout_q || (frz && wait_q == WW'(MAX_WAIT - 1));
    stall_d = (IDEX_Bubble && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
    frzc_d = (Freeze && frzc_q != '1) ? frzc_q + CNT_W'(1) : frzc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wait_q <= '0;
      timeout_q <= 1'b0;
      stall_q <= '0;
      frzc_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      timeout_q <= timeout_d;
      stall_q <= stall_d;
      frzc_q <= frzc_d;
    end
  end
  assign MemTimeout = timeout_q;
  assign StallCount = stall_q;
  assign FreezeCount = frzc_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: table-driven and directed checks of the stall/freeze controller
module tb_hazard_stall_unit;
  logic clk, rst;
  logic [4:0] IFID_Rs, IFID_Rt, IDEX_RegDest, EXMEM_RegDest;
  logic IFID_UsesRt, IFID_Branch, BranchTaken, IDEX_MemRead, EXMEM_MemRead, EXMEM_MemAccess, DMem_Ready;
  logic [1:0] IDEX_RegWrite;
  logic PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, Freeze, MemTimeout;
  logic [3:0] StallCount, FreezeCount;
  int pass_cnt = 0, total = 0;

  hazard_stall_unit #(.CNT_W(4), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
    .IFID_Branch(IFID_Branch), .BranchTaken(BranchTaken), .IDEX_RegDest(IDEX_RegDest),
    .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead), .EXMEM_RegDest(EXMEM_RegDest),
    .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemAccess(EXMEM_MemAccess), .DMem_Ready(DMem_Ready),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IDEX_Bubble(IDEX_Bubble), .IFID_Flush(IFID_Flush),
    .Freeze(Freeze), .MemTimeout(MemTimeout), .StallCount(StallCount), .FreezeCount(FreezeCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt; logic ut, br, tk;
    logic [4:0] xrd; logic [1:0] xrw; logic xmr;
    logic [4:0] mrd; logic mmr, mma, rdy;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[23];

  function automatic vec_t mk(input logic [4:0] rs, rt, input logic ut, br, tk,
                              input logic [4:0] xrd, input logic [1:0] xrw, input logic xmr,
                              input logic [4:0] mrd, input logic mmr, mma, rdy, input logic [4:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.ut = ut; v.br = br; v.tk = tk;
    v.xrd = xrd; v.xrw = xrw; v.xmr = xmr;
    v.mrd = mrd; v.mmr = mmr; v.mma = mma; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    IFID_Rs = v.rs; IFID_Rt = v.rt; IFID_UsesRt = v.ut; IFID_Branch = v.br; BranchTaken = v.tk;
    IDEX_RegDest = v.xrd; IDEX_RegWrite = v.xrw; IDEX_MemRead = v.xmr;
    EXMEM_RegDest = v.mrd; EXMEM_MemRead = v.mmr; EXMEM_MemAccess = v.mma; DMem_Ready = v.rdy;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] outs();
    return {27'd0, PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, Freeze};
  endfunction

  vec_t idle, lu5, ldex8, frzv;

  initial begin
    idle  = mk(0,0,0,0,0, 0,0,0, 0,0,0,1, 5'b11000);
    lu5   = mk(5,0,0,0,0, 5,1,1, 0,0,0,1, 5'b00100);
    ldex8 = mk(0,8,1,1,1, 8,1,1, 0,0,0,1, 5'b00100);
    frzv  = mk(0,0,0,0,0, 0,0,0, 0,0,1,0, 5'b00001);
    tbl[0]  = idle;
    tbl[1]  = mk(0,0,0,0,1, 0,0,0, 0,0,0,1, 5'b11010);
    tbl[2]  = lu5;
    tbl[3]  = idle;
    tbl[4]  = mk(3,5,0,0,0, 5,1,1, 0,0,0,1, 5'b11000);
    tbl[5]  = mk(3,5,1,0,0, 5,1,1, 0,0,0,1, 5'b00100);
    tbl[6]  = mk(5,0,0,0,0, 5,0,1, 0,0,0,1, 5'b11000);
    tbl[7]  = mk(0,0,0,0,0, 0,1,1, 0,0,0,1, 5'b11000);
    tbl[8]  = mk(7,0,0,1,1, 7,2,0, 0,0,0,1, 5'b00100);
    tbl[9]  = mk(7,0,0,0,0, 7,2,0, 0,0,0,1, 5'b11000);
    tbl[10] = ldex8;
    tbl[11] = mk(0,0,0,0,1, 0,0,0, 0,0,0,1, 5'b00100);
    tbl[12] = mk(0,0,0,0,1, 0,0,0, 0,0,0,1, 5'b11010);
    tbl[13] = mk(9,0,0,1,0, 0,0,0, 9,1,1,1, 5'b00100);
    tbl[14] = mk(9,0,0,0,0, 0,0,0, 9,1,1,1, 5'b11000);
    tbl[15] = mk(0,0,0,1,1, 0,1,0, 0,0,0,1, 5'b11010);
    tbl[16] = mk(5,0,0,0,1, 5,1,1, 0,0,1,0, 5'b00001);
    tbl[17] = mk(5,0,0,0,1, 5,1,1, 0,0,1,0, 5'b00001);
    tbl[18] = mk(5,0,0,0,1, 5,1,1, 0,0,1,1, 5'b00100);
    tbl[19] = mk(0,8,1,1,0, 8,1,1, 0,0,0,1, 5'b00100);
    tbl[20] = mk(0,0,0,0,1, 0,0,0, 0,0,1,0, 5'b00001);
    tbl[21] = mk(0,0,0,0,1, 0,0,0, 0,0,0,1, 5'b00100);
    tbl[22] = mk(0,0,0,0,1, 0,0,0, 0,0,0,1, 5'b11010);

    rst = 1'b1;
    apply(idle);
    #1 chk("reset_outs", outs(), 32'b00110);
    step();
    step();
    chk("reset_stallcnt", StallCount, 0);
    chk("reset_freezecnt", FreezeCount, 0);
    chk("reset_timeout", MemTimeout, 0);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      apply(tbl[i]);
      #1 chk($sformatf("vec%0d", i), outs(), {27'd0, tbl[i].exp});
      step();
    end
    apply(idle);
    chk("tbl_stallcnt", StallCount, 9);
    chk("tbl_freezecnt", FreezeCount, 3);
    chk("tbl_timeout", MemTimeout, 0);

    for (int k = 0; k < 3; k++) begin
      apply(frzv);
      #1 chk($sformatf("frz3_outs%0d", k), outs(), 32'b00001);
      step();
    end
    apply(idle);
    chk("frz3_cnt", FreezeCount, 6);
    chk("frz3_timeout", MemTimeout, 0);
    step();

    for (int k = 1; k <= 5; k++) begin
      apply(frzv);
      step();
      chk($sformatf("wd_timeout%0d", k), MemTimeout, (k >= 4) ? 1 : 0);
    end
    apply(idle);
    chk("wd_freezecnt", FreezeCount, 11);
    step();
    step();
    chk("wd_sticky", MemTimeout, 1);

    for (int k = 0; k < 6; k++) begin
      apply(frzv);
      step();
    end
    apply(idle);
    chk("frz_saturate", FreezeCount, 15);
    for (int k = 0; k < 6; k++) begin
      apply(lu5);
      step();
    end
    chk("stall_reach_max", StallCount, 15);
    step();
    step();
    apply(idle);
    chk("stall_saturate", StallCount, 15);
    step();

    apply(ldex8);
    step();
    apply(idle);
    rst = 1'b1;
    #1 chk("ldbr_reset_outs", outs(), 32'b00110);
    step();
    rst = 1'b0;
    #1 chk("post_reset_normal", outs(), 32'b11000);
    chk("post_reset_stallcnt", StallCount, 0);
    chk("post_reset_timeout", MemTimeout, 0);
    step();
    chk("post_reset_nostall", StallCount, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Stall/flush controller for the 5-stage pipelined CPU; the producer-side counterpart of operand forwarding. Detects the hazards forwarding cannot resolve (load-use, branch-compare-in-ID dependencies, data-memory wait states) and drives PC/IF-ID write enables, ID/EX bubble insertion, IF/ID flush and a global freeze. Sits in the ID stage beside the control unit; contains a small FSM, a memory-wait watchdog and saturating stall/freeze counters.

## Interface
- CNT_W, 16, width of the performance counters
- MAX_WAIT, 64, freeze cycles tolerated before MemTimeout
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- IFID_Rs  in  5  Rs of instruction in ID
- IFID_Rt  in  5  Rt of instruction in ID
- IFID_UsesRt  in  1  ID instruction reads Rt
- IFID_Branch  in  1  ID instruction is a branch (compared in ID)
- BranchTaken  in  1  branch in ID resolved taken
- IDEX_RegDest  in  5  destination of instruction in EX
- IDEX_RegWrite  in  2  nonzero = EX instruction writes a register
- IDEX_MemRead  in  1  EX instruction is a load
- EXMEM_RegDest  in  5  destination of instruction in MEM
- EXMEM_MemRead  in  1  MEM instruction is a load
- EXMEM_MemAccess  in  1  MEM instruction accesses data memory
- DMem_Ready  in  1  data memory completes access this cycle
- PCWrite  out  1  PC may update
- IFID_Write  out  1  IF/ID register may load
- IDEX_Bubble  out  1  load NOP control into ID/EX
- IFID_Flush  out  1  clear IF/ID (taken branch)
- Freeze  out  1  hold every pipeline register, including MEM/WB
- MemTimeout  out  1  sticky: freeze exceeded MAX_WAIT
- StallCount  out  CNT_W  saturating count of bubble cycles
- FreezeCount  out  CNT_W  saturating count of freeze cycles

## Operation
- Match(d) := d!=0 && (d==IFID_Rs || (IFID_UsesRt && d==IFID_Rt)).
- Hazard classes, evaluated in RUN only:
  - LU: IDEX_MemRead && IDEX_RegWrite!=0 && Match(IDEX_RegDest) -> 1 stall.
  - BR_ALU: IFID_Branch && IDEX_RegWrite!=0 && !IDEX_MemRead && Match(IDEX_RegDest) -> 1 stall.
  - BR_LDEX: IFID_Branch && IDEX_MemRead && IDEX_RegWrite!=0 && Match(IDEX_RegDest) -> 2 stalls (overrides LU).
  - BR_LDMEM: IFID_Branch && EXMEM_MemRead && Match(EXMEM_RegDest) -> 1 stall.
- Stall cycle outputs: PCWrite=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0.
- Normal cycle outputs: PCWrite=1, IFID_Write=1, IDEX_Bubble=0, IFID_Flush=BranchTaken.
- FSM states RUN, LD_BR:
  - RUN, no hazard -> normal, stay RUN.
  - RUN, LU/BR_ALU/BR_LDMEM -> stall, stay RUN.
  - RUN, BR_LDEX -> stall, next LD_BR.
  - LD_BR -> stall unconditionally (no re-evaluation), next RUN.
- Freeze := EXMEM_MemAccess && !DMem_Ready; highest priority in any state: PCWrite=0, IFID_Write=0, IDEX_Bubble=0, IFID_Flush=0, Freeze=1; FSM state held, hazard detection suppressed.
- BranchTaken ignored during stall or freeze cycles.
- Watchdog: wait counter increments each Freeze cycle, clears on any non-freeze cycle; when it reaches MAX_WAIT, MemTimeout sets and stays 1 until rst.
- StallCount +1 per cycle with IDEX_Bubble=1; FreezeCount +1 per cycle with Freeze=1; both saturate at 2^CNT_W-1, never wrap.

## Timing
- Control outputs combinational from current state and inputs, same cycle; state, watchdog, counters, MemTimeout registered.
- Reset (rst=1 at edge): state RUN, counters 0, MemTimeout 0. While rst=1 outputs forced: PCWrite=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=1, Freeze=0; counters do not count reset cycles.
- Reset in LD_BR aborts the pending stall; first cycle after reset is RUN.
- Freeze in LD_BR: LD_BR persists through the freeze; the remaining stall issues on the first non-freeze cycle.
- Freeze and hazard same cycle: freeze only; hazard re-evaluated next non-freeze cycle.
- MemTimeout rises on the edge ending freeze cycle MAX_WAIT.

## Test plan
- Load r5 in EX, ID reads Rs=5, Rt=0 -> exactly 1 cycle PCWrite=0, IDEX_Bubble=1; StallCount=1; next cycle normal.
- Load r8 in EX, ID branch with Rt=8, UsesRt=1 -> 2 consecutive stall cycles (RUN then LD_BR), StallCount=2; IFID_Flush=0 during both even with BranchTaken=1.
- ALU writes r0 in EX, ID branch reads r0 -> no stall; BranchTaken=1 -> IFID_Flush=1, PCWrite=1.
- EXMEM_MemAccess=1, DMem_Ready=0 for 3 cycles -> Freeze=1 for 3 cycles, IDEX_Bubble=0, FreezeCount=3, MemTimeout=0.
- MAX_WAIT=4, freeze held 5 cycles -> MemTimeout=1 after 4th freeze cycle, stays 1 after DMem_Ready=1; clears only on rst.
- Enter LD_BR, freeze 2 cycles, then release -> one further stall cycle, then RUN; rst asserted in LD_BR -> outputs at reset values, next cycle normal with no stall.
